// File: rtl/exposure_sequencer_if.sv
// Host/CCD-side signal bundle for the exposure sequencer.
// master = host and readout side that drives the requests; slave = the sequencer.
interface exposure_sequencer_if #(
  parameter int EXP_W = 24
) ();
  logic             start;
  logic             dark;
  logic             abort;
  logic [EXP_W-1:0] exposure_ms;
  logic             ccd_busy;
  logic             shutter_open;
  logic             ccd_toggle;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             error;
  logic [2:0]       state_out;

  modport master (
    output start, dark, abort, exposure_ms, ccd_busy,
    input  shutter_open, ccd_toggle, busy, done, aborted, error, state_out
  );

  modport slave (
    input  start, dark, abort, exposure_ms, ccd_busy,
    output shutter_open, ccd_toggle, busy, done, aborted, error, state_out
  );
endinterface

// File: rtl/exposure_sequencer.sv
// Runs one CCD frame: shutter open, timed exposure, shutter close, servo settle,
// readout trigger and wait for readout completion, with abort and busy-timeout handling.
module exposure_sequencer #(
  parameter int CLKS_PER_MS  = 100000,
  parameter int EXP_W        = 24,
  parameter int SETTLE_MS    = 250,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  exposure_sequencer_if.slave  bus
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PW-1:0]    PRESC_LAST  = PW'(CLKS_PER_MS - 1);
  localparam logic [EXP_W-1:0] SETTLE_LAST = EXP_W'(SETTLE_MS - 1);
  localparam logic [TW-1:0]    TMO_LAST    = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPEN   = 3'd1,
    S_EXPOSE = 3'd2,
    S_CLOSE  = 3'd3,
    S_TRIG   = 3'd4,
    S_READ   = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [EXP_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             seen_q, seen_d;
  logic [EXP_W-1:0] exposure_l_q, exposure_l_d;
  logic             dark_l_q, dark_l_d;
  logic             shutter_open_q, shutter_open_d;
  logic             ccd_toggle_q, ccd_toggle_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             error_q, error_d;

  logic ms_tick;
  logic settle_done;
  logic exp_done;

  assign ms_tick     = (presc_q == PRESC_LAST);
  assign settle_done = ms_tick && (ms_cnt_q == SETTLE_LAST);
  assign exp_done    = ms_tick && (ms_cnt_q == exposure_l_q - EXP_W'(1));

  always_comb begin
    state_d      = state_q;
    presc_d      = ms_tick ? '0 : presc_q + PW'(1);
    ms_cnt_d     = ms_tick ? ms_cnt_q + EXP_W'(1) : ms_cnt_q;
    tmo_d        = (state_q == S_READ) ? tmo_q + TW'(1) : '0;
    seen_d       = seen_q;
    exposure_l_d = exposure_l_q;
    dark_l_d     = dark_l_q;
    error_d      = error_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          exposure_l_d = bus.exposure_ms;
          dark_l_d     = bus.dark;
          error_d      = 1'b0;
          state_d      = S_OPEN;
        end
      end
      S_OPEN: begin
        if (bus.abort)
          state_d = S_ABORT;
        else if (settle_done)
          state_d = (exposure_l_q == '0) ? S_CLOSE : S_EXPOSE;
      end
      S_EXPOSE: begin
        // abort wins over an exposure that completes on the same cycle
        if (bus.abort)
          state_d = S_ABORT;
        else if (exp_done)
          state_d = S_CLOSE;
      end
      S_CLOSE: begin
        if (settle_done)
          state_d = S_TRIG;
      end
      S_TRIG: begin
        state_d = S_READ;
      end
      S_READ: begin
        if (!seen_q) begin
          if (bus.ccd_busy) begin
            seen_d = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (!bus.ccd_busy) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (settle_done) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // timebase and readout watch restart on every state entry
    if (state_d != state_q) begin
      presc_d  = '0;
      ms_cnt_d = '0;
      tmo_d    = '0;
      seen_d   = 1'b0;
    end

    // outputs decoded from the next state so they line up with the state register
    shutter_open_d = ((state_d == S_OPEN) || (state_d == S_EXPOSE)) && !dark_l_d;
    ccd_toggle_d   = (state_d == S_TRIG) || (state_q == S_TRIG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      ms_cnt_q       <= '0;
      tmo_q          <= '0;
      seen_q         <= 1'b0;
      shutter_open_q <= 1'b0;
      ccd_toggle_q   <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      ms_cnt_q       <= ms_cnt_d;
      tmo_q          <= tmo_d;
      seen_q         <= seen_d;
      shutter_open_q <= shutter_open_d;
      ccd_toggle_q   <= ccd_toggle_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      error_q        <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    exposure_l_q <= exposure_l_d;
    dark_l_q     <= dark_l_d;
  end

  assign bus.shutter_open = shutter_open_q;
  assign bus.ccd_toggle   = ccd_toggle_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.error        = error_q;
  assign bus.state_out    = state_q;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer: expected output events are queued with
// their cycle numbers when each frame is started and matched as the DUT emits them.
module tb_exposure_sequencer;

  localparam int EV_TOG  = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ABT  = 3;
  localparam int EV_ERR  = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  exposure_sequencer_if #(.EXP_W(24)) bus ();

  exposure_sequencer #(
    .CLKS_PER_MS (10),
    .EXP_W       (24),
    .SETTLE_MS   (2),
    .BUSY_TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   shutter_cnt = 0;
  int   tog_w = 0;
  bit   tog_prev = 1'b0;
  bit   err_prev = 1'b0;
  bit   saw_expose = 1'b0;
  bit   model_en = 1'b1;

  // readout model: busy rises 5 cycles after the toggle and falls at cycle 100
  initial begin
    bus.ccd_busy = 1'b0;
    forever begin
      @(posedge bus.ccd_toggle);
      if (model_en) begin
        repeat (5) @(posedge clk);
        #1 bus.ccd_busy = 1'b1;
        repeat (95) @(posedge clk);
        #1 bus.ccd_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic got_event(input int kind);
    ev_t e;
    checks++;
    assert (exp_q.size() !== 0) else begin
      errors++;
      $error("FAIL unexpected_event: observed kind %0d at cycle %0d expected none", kind, cyc);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("event_kind_at_%0d", e.cyc), kind, e.kind);
      check($sformatf("event_cycle_kind_%0d", e.kind), cyc, e.cyc);
    end
  endtask

  task automatic sample();
    if (bus.ccd_toggle && !tog_prev) got_event(EV_TOG);
    if (bus.done) got_event(EV_DONE);
    if (bus.aborted) got_event(EV_ABT);
    if (bus.error && !err_prev) got_event(EV_ERR);
    if (bus.ccd_toggle) tog_w++;
    else if (tog_prev) begin
      check("toggle_width", tog_w, 2);
      tog_w = 0;
    end
    if (bus.shutter_open) shutter_cnt++;
    if (bus.state_out == 3'd2) saw_expose = 1'b1;
    tog_prev = bus.ccd_toggle;
    err_prev = bus.error;
  endtask

  // one clock: sample mid-cycle, then return just after the next rising edge
  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_pending_events"}, exp_q.size(), 0);
  endtask

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic start_frame(input bit d, input int e, output int s);
    shutter_cnt       = 0;
    saw_expose        = 1'b0;
    s                 = cyc;
    bus.start         = 1'b1;
    bus.dark          = d;
    bus.exposure_ms   = 24'(e);
    step();
    bus.start         = 1'b0;
  endtask

  function automatic int outs_vec();
    return int'({bus.shutter_open, bus.ccd_toggle, bus.busy, bus.done,
                 bus.aborted, bus.error, bus.state_out});
  endfunction

  initial begin
    int s;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.dark        = 1'b0;
    bus.abort       = 1'b0;
    bus.exposure_ms = '0;
    run(3);
    check("reset_outputs", outs_vec(), 0);
    rst = 1'b0;
    run(2);
    check("idle_after_reset", outs_vec(), 0);

    // light frame, 3 ms
    start_frame(1'b0, 3, s);
    check("light_shutter_first_cycle", int'(bus.shutter_open), 1);
    push(EV_TOG, s + 71);
    push(EV_DONE, s + 172);
    wait_drain("light", 250);
    run(5);
    check("light_shutter_cycles", shutter_cnt, 50);
    check("light_idle", int'(bus.state_out), 0);

    // dark frame, 3 ms
    start_frame(1'b1, 3, s);
    push(EV_TOG, s + 71);
    push(EV_DONE, s + 172);
    wait_drain("dark", 250);
    run(5);
    check("dark_shutter_cycles", shutter_cnt, 0);
    check("dark_saw_expose", int'(saw_expose), 1);

    // zero-length exposure skips EXPOSE
    start_frame(1'b0, 0, s);
    push(EV_TOG, s + 41);
    push(EV_DONE, s + 142);
    wait_drain("exp0", 200);
    run(5);
    check("exp0_shutter_cycles", shutter_cnt, 20);
    check("exp0_saw_expose", int'(saw_expose), 0);

    // abort in the middle of the exposure
    start_frame(1'b0, 3, s);
    run(29);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_shutter_closed", int'(bus.shutter_open), 0);
    check("abort_state", int'(bus.state_out), 6);
    push(EV_ABT, s + 51);
    run(8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("abort_start_ignored", int'(bus.state_out), 6);
    wait_drain("abort", 60);
    run(5);
    check("abort_shutter_cycles", shutter_cnt, 30);
    check("abort_idle", int'(bus.state_out), 0);

    // start and abort together in IDLE
    bus.abort = 1'b1;
    start_frame(1'b0, 3, s);
    check("startabort_open", int'(bus.state_out), 1);
    step();
    bus.abort = 1'b0;
    check("startabort_abort_state", int'(bus.state_out), 6);
    push(EV_ABT, s + 22);
    wait_drain("startabort", 60);
    run(3);
    check("startabort_shutter_cycles", shutter_cnt, 1);

    // readout never reports busy
    model_en = 1'b0;
    start_frame(1'b0, 0, s);
    push(EV_TOG, s + 41);
    push(EV_ERR, s + 50);
    wait_drain("timeout", 100);
    run(20);
    check("timeout_error_sticky", int'(bus.error), 1);
    check("timeout_idle", int'(bus.state_out), 0);
    model_en = 1'b1;
    start_frame(1'b0, 0, s);
    check("error_cleared_by_start", int'(bus.error), 0);
    push(EV_TOG, s + 41);
    push(EV_DONE, s + 142);
    wait_drain("after_error", 200);
    run(5);

    // reset during the exposure
    start_frame(1'b0, 3, s);
    run(24);
    check("pre_rst_expose", int'(bus.state_out), 2);
    rst = 1'b1;
    step();
    check("rst_in_expose_outputs", outs_vec(), 0);
    rst = 1'b0;
    run(30);
    check("rst_stays_idle", outs_vec(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
